rcv_frame_filter: RTL and testbench

Receive-side frame filter sitting directly downstream of the Manchester receiver byte decoder and feeding both the UART output path and the transmit controller's ACK inputs. It takes post-SFD frame bytes (dest, src, ftype, payload, CRC), checks address, type and CRC-8, and buffers payload in a circular store that is committed only when the frame is good. It raises `ACK_needed`/`ack_addr` toward the transmitter for acknowledged unicast frames and pulses `ACK_received` when an ACK addressed to this station arrives.

---
 rtl/rcv_frame_filter.sv | 179 +++++++++++++++++
 tb/tb_rcv_frame_filter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rcv_frame_filter.sv
// Receive frame filter: address/type/CRC-8 check, circular payload store committed on good frames; RX_BROADCAST_EN accepts BCAST_ADDR.
// Verdict 1 cycle after rframe falls, payload out <=2 cycles after commit; pdata holds until prdy, full buffer rejects the frame.
module rcv_frame_filter #(
  parameter int          BUF_AW     = 8,
  parameter logic [7:0]  BCAST_ADDR = 8'h2A
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] mac,
  input  logic [7:0] rdata,
  input  logic       rvalid,
  input  logic       rframe,
  input  logic       rerr,
  input  logic       ack_done,
  input  logic       prdy,
  output logic [7:0] pdata,
  output logic       pvalid,
  output logic       ACK_needed,
  output logic [7:0] ack_addr,
  output logic       ACK_received,
  output logic [7:0] rerrcnt
);

`ifdef RX_BROADCAST_EN
  localparam bit BCAST_EN = 1'b1;
`else
  localparam bit BCAST_EN = 1'b0;
`endif

  localparam logic [7:0] FT_DATA     = 8'h30;
  localparam logic [7:0] FT_DATA_ACK = 8'h31;
  localparam logic [7:0] FT_ACK      = 8'h33;

  typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, CHECK, DROP} state_t;

  state_t state, state_n;

  logic              rframe_q;
  logic [7:0]        crc, dest, src, ftype;
  logic [15:0]       cnt;
  logic              ovf, err_seen;
  logic [BUF_AW-1:0] wr_ptr, wr_commit, rd_ptr;
  logic [7:0]        mem [0:(1<<BUF_AW)-1];

  logic rise, dest_ok, buf_full, byte_hdr, byte_pay, do_write;
  logic frame_good, type_data, to_me, commit, ack_set, ack_rx, count_err, rd_load;

  function automatic logic [7:0] crc8_next(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      r = (r[7] ^ d[i]) ? ((r << 1) ^ 8'h07) : (r << 1);
    end
    return r;
  endfunction

  assign rise     = rframe & ~rframe_q;
  assign dest_ok  = (rdata == mac) | (BCAST_EN & (rdata == BCAST_ADDR));
  assign buf_full = (wr_ptr + 1'b1) == rd_ptr;
  assign byte_hdr = (state == HDR) & rvalid;
  assign byte_pay = (state == PAYLOAD) & rvalid;
  assign do_write = byte_pay & ~ovf & ~buf_full;

  assign frame_good = (cnt >= 16'd4) & (crc == 8'h00) & ~err_seen & ~ovf;
  assign type_data  = (ftype == FT_DATA) | (ftype == FT_DATA_ACK);
  assign to_me      = (dest == mac);
  assign commit     = (state == CHECK) & frame_good & type_data;
  assign ack_set    = commit & (ftype == FT_DATA_ACK) & to_me;
  assign ack_rx     = (state == CHECK) & frame_good & (ftype == FT_ACK) & to_me;
  assign count_err  = (state == CHECK) & (~frame_good | ~(type_data | (ftype == FT_ACK)));
  assign rd_load    = (rd_ptr != wr_commit) & (~pvalid | prdy);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // A bad first byte wins over a coincident rframe fall so that wrong-address frames are never counted.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (rise) state_n = HDR;
      HDR: begin
        if (rvalid && cnt == 16'd0 && !dest_ok) state_n = DROP;
        else if (!rframe)                       state_n = CHECK;
        else if (rvalid && cnt == 16'd2)        state_n = PAYLOAD;
      end
      PAYLOAD: if (!rframe) state_n = CHECK;
      CHECK:   state_n = IDLE;
      DROP:    if (!rframe) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // rframe_q resets high so a frame already in flight at reset release is ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rframe_q  <= 1'b1;
      crc       <= 8'h00;
      cnt       <= 16'd0;
      dest      <= 8'h00;
      src       <= 8'h00;
      ftype     <= 8'h00;
      ovf       <= 1'b0;
      err_seen  <= 1'b0;
      wr_ptr    <= '0;
      wr_commit <= '0;
    end else begin
      rframe_q <= rframe;
      if (state == IDLE && rise) begin
        crc      <= 8'h00;
        cnt      <= 16'd0;
        ovf      <= 1'b0;
        err_seen <= 1'b0;
        wr_ptr   <= wr_commit;
      end
      if (state == HDR || state == PAYLOAD) err_seen <= err_seen | rerr;
      if (byte_hdr || byte_pay) begin
        crc <= crc8_next(crc, rdata);
        if (cnt != 16'hFFFF) cnt <= cnt + 16'd1;
      end
      if (byte_hdr) begin
        case (cnt)
          16'd0:   dest  <= rdata;
          16'd1:   src   <= rdata;
          16'd2:   ftype <= rdata;
          default: ;
        endcase
      end
      if (byte_pay) begin
        if (do_write) wr_ptr <= wr_ptr + 1'b1;
        else          ovf    <= 1'b1;
      end
      // The CRC byte was stored too; it is dropped by committing one short.
      if (state == CHECK) begin
        if (commit) wr_commit <= wr_ptr - 1'b1;
        else        wr_ptr    <= wr_commit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= rdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ACK_needed   <= 1'b0;
      ack_addr     <= 8'h00;
      ACK_received <= 1'b0;
      rerrcnt      <= 8'h00;
    end else begin
      ACK_received <= ack_rx;
      if (ack_set) begin
        ACK_needed <= 1'b1;
        ack_addr   <= src;
      end else if (ack_done) begin
        ACK_needed <= 1'b0;
      end
      if (count_err && rerrcnt != 8'hFF) rerrcnt <= rerrcnt + 8'd1;
    end
  end

  // Output register: refilled whenever empty or being consumed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pdata  <= 8'h00;
      pvalid <= 1'b0;
      rd_ptr <= '0;
    end else if (rd_load) begin
      pdata  <= mem[rd_ptr];
      pvalid <= 1'b1;
      rd_ptr <= rd_ptr + 1'b1;
    end else if (prdy) begin
      pvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rcv_frame_filter.sv
// Randomized bench for rcv_frame_filter against a queue-based frame model.
module tb_rcv_frame_filter;
  localparam int         AW    = 3;
  localparam int         DEPTH = 1 << AW;
  localparam logic [7:0] MAC   = 8'h41;
  localparam logic [7:0] BCAST = 8'h2A;
`ifdef RX_BROADCAST_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  typedef logic [7:0] bq_t [$];

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rdata;
  logic       rvalid, rframe, rerr, ack_done, prdy;
  logic [7:0] pdata, ack_addr, rerrcnt;
  logic       pvalid, ACK_needed, ACK_received;

  always #5 clk = ~clk;

  rcv_frame_filter #(.BUF_AW(AW), .BCAST_ADDR(BCAST)) dut (
    .clk(clk), .rst(rst), .mac(MAC), .rdata(rdata), .rvalid(rvalid),
    .rframe(rframe), .rerr(rerr), .ack_done(ack_done), .prdy(prdy),
    .pdata(pdata), .pvalid(pvalid), .ACK_needed(ACK_needed),
    .ack_addr(ack_addr), .ACK_received(ACK_received), .rerrcnt(rerrcnt)
  );

  int checks = 0;
  int passes = 0;

  logic [7:0] exp_q[$];
  int         got_q[$];
  int         exp_err = 0;
  bit         exp_ackn = 0;
  logic [7:0] exp_acka = 8'h00;
  int         exp_ackrx = 0;
  int         got_ackrx = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (pvalid && prdy) got_q.push_back(int'(pdata));
      if (ACK_received) got_ackrx++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Remainder of the bit string (bytes MSB first, then zbits zeros) modulo x^8+x^2+x+1.
  function automatic logic [7:0] poly_mod(input bq_t m, input int zbits);
    int r = 0;
    foreach (m[i]) begin
      for (int b = 7; b >= 0; b--) begin
        r = (r << 1) | int'(m[i][b]);
        if ((r & 'h100) != 0) r = r ^ 'h107;
      end
    end
    for (int b = 0; b < zbits; b++) begin
      r = r << 1;
      if ((r & 'h100) != 0) r = r ^ 'h107;
    end
    return 8'(r);
  endfunction

  function automatic bq_t make_frame(input logic [7:0] d, input logic [7:0] s,
                                     input logic [7:0] t, input bq_t pl, input bit bad);
    bq_t f;
    logic [7:0] c;
    f = {d, s, t};
    foreach (pl[i]) f.push_back(pl[i]);
    c = poly_mod(f, 8);
    if (bad) c = c ^ 8'h5A;
    f.push_back(c);
    return f;
  endfunction

  task automatic model_frame(input bq_t fr, input bit rerr_on);
    int n, writes;
    bit acc, good;
    n = fr.size();
    acc = (fr[0] == MAC) || (BC && fr[0] == BCAST);
    if (!acc) return;
    writes = (n > 3) ? n - 3 : 0;
    good = (n >= 4) && (poly_mod(fr, 0) == 8'h00) && !rerr_on &&
           (writes <= DEPTH - 1 - exp_q.size());
    if (!good) begin
      if (exp_err < 255) exp_err++;
      return;
    end
    if (fr[2] == 8'h30 || fr[2] == 8'h31) begin
      for (int i = 3; i < n - 1; i++) exp_q.push_back(fr[i]);
      if (fr[2] == 8'h31 && fr[0] == MAC) begin
        exp_ackn = 1;
        exp_acka = fr[1];
      end
    end else if (fr[2] == 8'h33) begin
      if (fr[0] == MAC) exp_ackrx++;
    end else if (exp_err < 255) begin
      exp_err++;
    end
  endtask

  task automatic send_frame(input bq_t fr, input bit rerr_on, input bit coincide);
    rframe = 1'b1;
    rerr   = rerr_on;
    tick();
    foreach (fr[i]) begin
      repeat ($urandom_range(0, 1)) tick();
      rdata  = fr[i];
      rvalid = 1'b1;
      if (coincide && i == fr.size() - 1) rframe = 1'b0;
      tick();
      rvalid = 1'b0;
    end
    if (!coincide) begin
      repeat ($urandom_range(0, 1)) tick();
      rframe = 1'b0;
      tick();
    end
    rerr = 1'b0;
    repeat (3) tick();
  endtask

  task automatic check_state(input string tag);
    check({tag, ".rerrcnt"}, int'(rerrcnt), exp_err);
    check({tag, ".ack_needed"}, int'(ACK_needed), int'(exp_ackn));
    check({tag, ".ack_addr"}, int'(ack_addr), int'(exp_acka));
    check({tag, ".ack_rx"}, got_ackrx, exp_ackrx);
  endtask

  task automatic drain(input string tag);
    int budget = 400;
    while (got_q.size() < exp_q.size() && budget > 0) begin
      prdy = 1'($urandom_range(0, 1));
      tick();
      budget--;
    end
    prdy = 1'b1;
    repeat (4) tick();
    prdy = 1'b0;
    while (exp_q.size() > 0) begin
      logic [7:0] e;
      int g;
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : -1;
      check({tag, ".pdata"}, g, int'(e));
    end
    check({tag, ".extra_bytes"}, got_q.size(), 0);
    got_q.delete();
    check({tag, ".pvalid_idle"}, int'(pvalid), 0);
  endtask

  task automatic do_frame(input string tag, input bq_t fr, input bit rerr_on, input bit coincide);
    model_frame(fr, rerr_on);
    send_frame(fr, rerr_on, coincide);
    check_state(tag);
  endtask

  task automatic ack_pulse();
    ack_done = 1'b1;
    tick();
    ack_done = 1'b0;
    tick();
    exp_ackn = 0;
    check("ack_done.clear", int'(ACK_needed), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bq_t fr, pl;
    rst = 1'b0; rdata = 8'h00; rvalid = 1'b0; rframe = 1'b0;
    rerr = 1'b0; ack_done = 1'b0; prdy = 1'b0;
    tick(); tick();
    check("reset.pvalid", int'(pvalid), 0);
    check("reset.pdata", int'(pdata), 0);
    check("reset.ack_needed", int'(ACK_needed), 0);
    check("reset.ack_addr", int'(ack_addr), 0);
    check("reset.ack_received", int'(ACK_received), 0);
    check("reset.rerrcnt", int'(rerrcnt), 0);
    rst = 1'b1;
    tick(); tick();

    pl = {8'h48, 8'h69};
    do_frame("hi_30", make_frame(MAC, 8'h42, 8'h30, pl, 0), 0, 0);
    drain("hi_30");

    do_frame("hi_31", make_frame(MAC, 8'h42, 8'h31, pl, 0), 0, 1);
    drain("hi_31");
    ack_pulse();

    pl = {8'h58};
    do_frame("bad_crc", make_frame(MAC, 8'h42, 8'h31, pl, 1), 0, 0);
    drain("bad_crc");

    pl = {};
    do_frame("ack_me", make_frame(MAC, 8'h42, 8'h33, pl, 0), 0, 0);
    do_frame("ack_other", make_frame(8'h43, 8'h42, 8'h33, pl, 0), 0, 0);

    pl = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    do_frame("ovf_first", make_frame(MAC, 8'h42, 8'h30, pl, 0), 0, 0);
    pl = {8'h11, 8'h12, 8'h13, 8'h14};
    do_frame("ovf_second", make_frame(MAC, 8'h42, 8'h30, pl, 0), 0, 0);
    drain("ovf");

    pl = {8'h42};
    do_frame("bcast", make_frame(BCAST, 8'h42, 8'h31, pl, 0), 0, 0);
    drain("bcast");

    // Reset in the middle of a frame discards it and all counters.
    fr = make_frame(MAC, 8'h42, 8'h30, pl, 0);
    rframe = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      rdata = fr[i]; rvalid = 1'b1; tick(); rvalid = 1'b0;
    end
    rst = 1'b0;
    tick();
    rframe = 1'b0;
    check("midreset.pvalid", int'(pvalid), 0);
    check("midreset.rerrcnt", int'(rerrcnt), 0);
    check("midreset.ack_needed", int'(ACK_needed), 0);
    rst = 1'b1;
    tick(); tick();
    exp_q.delete(); got_q.delete();
    exp_err = 0; exp_ackn = 0; exp_acka = 8'h00; exp_ackrx = 0; got_ackrx = 0;
    pl = {8'h77, 8'h88};
    do_frame("after_reset", make_frame(MAC, 8'h42, 8'h30, pl, 0), 0, 0);
    drain("after_reset");

    for (int k = 0; k < 40; k++) begin
      logic [7:0] d, t;
      int sel, plen;
      sel = $urandom_range(0, 3);
      case (sel)
        0: t = 8'h30;
        1: t = 8'h31;
        2: t = 8'h33;
        default: t = 8'h37;
      endcase
      sel = $urandom_range(0, 5);
      d = (sel < 4) ? MAC : ((sel == 4 && t != 8'h33) ? BCAST : 8'h43);
      plen = (t == 8'h33) ? 0 : $urandom_range(0, 4);
      pl = {};
      for (int i = 0; i < plen; i++) pl.push_back(8'($urandom()));
      fr = make_frame(d, 8'($urandom()), t, pl, $urandom_range(0, 4) == 0);
      if ($urandom_range(0, 7) == 0) begin
        int keep = $urandom_range(1, 3);
        while (fr.size() > keep) void'(fr.pop_back());
      end
      do_frame("rand", fr, $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)));
      drain("rand");
      if (exp_ackn && $urandom_range(0, 1) == 1) ack_pulse();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
